// File: rtl/decode_pkg.sv
// decode_pkg
//   Shared types and constants for the RV32I decode queue.
//   - ctrl_t      : decoded control bundle (reg_write is the MSB, illegal the LSB)
//   - CTRL_W      : packed width of ctrl_t
//   - OPC_*       : major opcode values
//   - CTRL_*      : control bundle for each legal opcode row
//   - ctrl_illegal: bundle for an instruction that must not execute
package decode_pkg;

  typedef enum logic [1:0] {
    ALUA_RS1  = 2'b00,
    ALUA_PC   = 2'b01,
    ALUA_ZERO = 2'b10
  } alu_a_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_JAL  = 2'b01,
    JMP_JALR = 2'b10
  } jump_e;

  typedef struct packed {
    logic        reg_write;
    logic [2:0]  imm_src;
    logic        alu_src;
    alu_a_e      alu_a_src;
    logic        mem_write;
    result_src_e result_src;
    logic        branch;
    jump_e       jump;
    logic [1:0]  alu_op;
    logic        system;
    logic        illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam ctrl_t CTRL_NOP = '{reg_write:1'b0, imm_src:3'b000, alu_src:1'b0,
    alu_a_src:ALUA_RS1, mem_write:1'b0, result_src:RES_ALU, branch:1'b0,
    jump:JMP_NONE, alu_op:2'b00, system:1'b0, illegal:1'b0};

  localparam ctrl_t CTRL_LOAD = '{reg_write:1'b1, imm_src:3'b001, alu_src:1'b1,
    alu_a_src:ALUA_RS1, mem_write:1'b0, result_src:RES_MEM, branch:1'b0,
    jump:JMP_NONE, alu_op:2'b00, system:1'b0, illegal:1'b0};

  localparam ctrl_t CTRL_OPIMM = '{reg_write:1'b1, imm_src:3'b001, alu_src:1'b1,
    alu_a_src:ALUA_RS1, mem_write:1'b0, result_src:RES_ALU, branch:1'b0,
    jump:JMP_NONE, alu_op:2'b10, system:1'b0, illegal:1'b0};

  localparam ctrl_t CTRL_STORE = '{reg_write:1'b0, imm_src:3'b010, alu_src:1'b1,
    alu_a_src:ALUA_RS1, mem_write:1'b1, result_src:RES_ALU, branch:1'b0,
    jump:JMP_NONE, alu_op:2'b00, system:1'b0, illegal:1'b0};

  localparam ctrl_t CTRL_OP = '{reg_write:1'b1, imm_src:3'b000, alu_src:1'b0,
    alu_a_src:ALUA_RS1, mem_write:1'b0, result_src:RES_ALU, branch:1'b0,
    jump:JMP_NONE, alu_op:2'b10, system:1'b0, illegal:1'b0};

  localparam ctrl_t CTRL_BRANCH = '{reg_write:1'b0, imm_src:3'b011, alu_src:1'b0,
    alu_a_src:ALUA_RS1, mem_write:1'b0, result_src:RES_ALU, branch:1'b1,
    jump:JMP_NONE, alu_op:2'b01, system:1'b0, illegal:1'b0};

  localparam ctrl_t CTRL_LUI = '{reg_write:1'b1, imm_src:3'b100, alu_src:1'b1,
    alu_a_src:ALUA_ZERO, mem_write:1'b0, result_src:RES_ALU, branch:1'b0,
    jump:JMP_NONE, alu_op:2'b00, system:1'b0, illegal:1'b0};

  localparam ctrl_t CTRL_AUIPC = '{reg_write:1'b1, imm_src:3'b100, alu_src:1'b1,
    alu_a_src:ALUA_PC, mem_write:1'b0, result_src:RES_ALU, branch:1'b0,
    jump:JMP_NONE, alu_op:2'b00, system:1'b0, illegal:1'b0};

  localparam ctrl_t CTRL_JAL = '{reg_write:1'b1, imm_src:3'b101, alu_src:1'b1,
    alu_a_src:ALUA_PC, mem_write:1'b0, result_src:RES_PC4, branch:1'b0,
    jump:JMP_JAL, alu_op:2'b00, system:1'b0, illegal:1'b0};

  localparam ctrl_t CTRL_JALR = '{reg_write:1'b1, imm_src:3'b001, alu_src:1'b1,
    alu_a_src:ALUA_RS1, mem_write:1'b0, result_src:RES_PC4, branch:1'b0,
    jump:JMP_JALR, alu_op:2'b00, system:1'b0, illegal:1'b0};

  // Illegal entries carry no side-effect bits so execute can trap on them safely.
  function automatic ctrl_t ctrl_illegal();
    ctrl_t c;
    c = CTRL_NOP;
    c.illegal = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/decode_ctrl_rom.sv
// decode_ctrl_rom
//   Combinational RV32I control decode: opcode table plus funct3 legality checks.
//   Ports:
//     instr  in   32      instruction word
//     ctrl   out  ctrl_t  decoded control bundle
module decode_ctrl_rom
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];

  // Opcode lookup; funct3 encodings with no defined operation decode as illegal.
  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode_s)
      OPC_LOAD: begin
        if ((funct3_s == 3'b011) || (funct3_s == 3'b110) || (funct3_s == 3'b111)) begin
          ctrl = ctrl_illegal();
        end else begin
          ctrl = CTRL_LOAD;
        end
      end
      OPC_STORE: begin
        if (funct3_s > 3'b010) begin
          ctrl = ctrl_illegal();
        end else begin
          ctrl = CTRL_STORE;
        end
      end
      OPC_BRANCH: begin
        if ((funct3_s == 3'b010) || (funct3_s == 3'b011)) begin
          ctrl = ctrl_illegal();
        end else begin
          ctrl = CTRL_BRANCH;
        end
      end
      OPC_JALR: begin
        if (funct3_s != 3'b000) begin
          ctrl = ctrl_illegal();
        end else begin
          ctrl = CTRL_JALR;
        end
      end
      OPC_OPIMM:  ctrl = CTRL_OPIMM;
      OPC_OP:     ctrl = CTRL_OP;
      OPC_LUI:    ctrl = CTRL_LUI;
      OPC_AUIPC:  ctrl = CTRL_AUIPC;
      OPC_JAL:    ctrl = CTRL_JAL;
      OPC_FENCE:  ctrl = CTRL_NOP;
      OPC_SYSTEM: begin
        ctrl = CTRL_NOP;
        ctrl.system = 1'b1;
      end
      default:    ctrl = ctrl_illegal();
    endcase
  end

endmodule

// File: rtl/decode_ctrl_queue.sv
// decode_ctrl_queue
//   Decode stage between fetch and execute: decodes on push and buffers
//   {ctrl, instr, pc} in a DEPTH-entry FIFO with valid/ready on both sides
//   and a synchronous flush for branch redirects.
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     flush_i                         drop queue contents and same-cycle input
//     in_valid_i/in_ready_o           fetch handshake (ready from registered count)
//     in_instr_i, in_pc_i             instruction and its PC
//     out_valid_o/out_ready_i         execute handshake
//     out_ctrl_o, out_instr_o, out_pc_o  head entry (all zero when not valid)
//   Optional feature macro DECODE_PERF_CNT_EN adds:
//     perf_decoded_o, perf_illegal_o  32-bit wrapping push / illegal-push counters
module decode_ctrl_queue
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       in_instr_i,
  input  logic [XLEN-1:0]   in_pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [31:0]       out_instr_o,
  output logic [XLEN-1:0]   out_pc_o
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_decoded_o,
  output logic [31:0]       perf_illegal_o
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  ctrl_t             dec_ctrl_s;
  ctrl_t             ctrl_mem_r  [DEPTH];
  logic [31:0]       instr_mem_r [DEPTH];
  logic [XLEN-1:0]   pc_mem_r    [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_nxt_s;
  logic              out_valid_r;
  logic              in_ready_r;
  logic              push_s;
  logic              pop_s;

  // Pointer advance with explicit wrap so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : (p + PW'(1));
  endfunction

  decode_ctrl_rom u_rom (
    .instr (in_instr_i),
    .ctrl  (dec_ctrl_s)
  );

  assign push_s      = in_valid_i & in_ready_r & ~flush_i;
  assign pop_s       = out_valid_r & out_ready_i & ~flush_i;
  assign in_ready_o  = in_ready_r;
  assign out_valid_o = out_valid_r;

  // Next occupancy; flush wins over any same-cycle push or pop.
  always_comb begin
    count_nxt_s = count_r;
    if (flush_i) begin
      count_nxt_s = {CW{1'b0}};
    end else if (push_s && !pop_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Occupancy, pointers and the registered handshake flags derived from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r     <= {CW{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      count_r     <= count_nxt_s;
      out_valid_r <= (count_nxt_s != {CW{1'b0}});
      in_ready_r  <= (count_nxt_s != CW'(DEPTH));
      if (flush_i) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
      end else begin
        if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
        if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
    end
  end

  // Entry storage, written with the freshly decoded bundle on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_mem_r[i]  <= CTRL_NOP;
        instr_mem_r[i] <= 32'h0000_0000;
        pc_mem_r[i]    <= {XLEN{1'b0}};
      end
    end else if (push_s) begin
      ctrl_mem_r[wr_ptr_r]  <= dec_ctrl_s;
      instr_mem_r[wr_ptr_r] <= in_instr_i;
      pc_mem_r[wr_ptr_r]    <= in_pc_i;
    end
  end

  // Head data is forced to zero while nothing valid is presented.
  always_comb begin
    if (out_valid_r) begin
      out_ctrl_o  = ctrl_mem_r[rd_ptr_r];
      out_instr_o = instr_mem_r[rd_ptr_r];
      out_pc_o    = pc_mem_r[rd_ptr_r];
    end else begin
      out_ctrl_o  = {CTRL_W{1'b0}};
      out_instr_o = 32'h0000_0000;
      out_pc_o    = {XLEN{1'b0}};
    end
  end

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] perf_decoded_r;
  logic [31:0] perf_illegal_r;

  // Push statistics; survive flush so redirect-heavy code stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_decoded_r <= 32'h0000_0000;
      perf_illegal_r <= 32'h0000_0000;
    end else if (push_s) begin
      perf_decoded_r <= perf_decoded_r + 32'h0000_0001;
      if (dec_ctrl_s.illegal) perf_illegal_r <= perf_illegal_r + 32'h0000_0001;
    end
  end

  assign perf_decoded_o = perf_decoded_r;
  assign perf_illegal_o = perf_illegal_r;
`endif

endmodule

// File: tb/tb_decode_ctrl_queue.sv
// tb_decode_ctrl_queue
//   Directed self-checking bench for decode_ctrl_queue (DEPTH=2, XLEN=32).
//   Expected control bundles are written out as hand-computed field
//   concatenations in the order reg_write..illegal.
module tb_decode_ctrl_queue;
  import decode_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [31:0]       in_instr_i;
  logic [31:0]       in_pc_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic [31:0]       out_instr_o;
  logic [31:0]       out_pc_o;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0]       perf_decoded_o;
  logic [31:0]       perf_illegal_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // {rw, imm[2:0], as, aa[1:0], mw, rs[1:0], br, j[1:0], aop[1:0], sys, ill}
  localparam logic [16:0] E_LOAD   = {1'b1, 3'b001, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [16:0] E_OPIMM  = {1'b1, 3'b001, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0};
  localparam logic [16:0] E_STORE  = {1'b0, 3'b010, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [16:0] E_OP     = {1'b1, 3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0};
  localparam logic [16:0] E_BRANCH = {1'b0, 3'b011, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0};
  localparam logic [16:0] E_LUI    = {1'b1, 3'b100, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [16:0] E_AUIPC  = {1'b1, 3'b100, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [16:0] E_JAL    = {1'b1, 3'b101, 1'b1, 2'b01, 1'b0, 2'b10, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
  localparam logic [16:0] E_JALR   = {1'b1, 3'b001, 1'b1, 2'b00, 1'b0, 2'b10, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0};
  localparam logic [16:0] E_FENCE  = 17'h0_0000;
  localparam logic [16:0] E_SYSTEM = 17'h0_0002;
  localparam logic [16:0] E_ILL    = 17'h0_0001;

  decode_ctrl_queue #(.XLEN(32), .DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_instr_i  (in_instr_i),
    .in_pc_i     (in_pc_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_ctrl_o  (out_ctrl_o),
    .out_instr_o (out_instr_o),
    .out_pc_o    (out_pc_o)
`ifdef DECODE_PERF_CNT_EN
    ,
    .perf_decoded_o (perf_decoded_o),
    .perf_illegal_o (perf_illegal_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one instruction with the consumer stalled, then leave the input idle.
  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid_i = 1'b1;
    in_instr_i = instr;
    in_pc_i    = pc;
    step();
    in_valid_i = 1'b0;
  endtask

  // Consume the head for one cycle.
  task automatic pop();
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
  endtask

  logic [31:0] tbl_instr [9];
  logic [16:0] tbl_exp   [9];

  initial begin
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    in_instr_i  = 32'h0000_0000;
    in_pc_i     = 32'h0000_0000;

    tbl_instr[0] = 32'h0000_00B7; tbl_exp[0] = E_LUI;
    tbl_instr[1] = 32'h0000_0017; tbl_exp[1] = E_AUIPC;
    tbl_instr[2] = 32'h0000_0063; tbl_exp[2] = E_BRANCH;
    tbl_instr[3] = 32'h0000_2063; tbl_exp[3] = E_ILL;     // branch funct3=010
    tbl_instr[4] = 32'h0000_0073; tbl_exp[4] = E_SYSTEM;
    tbl_instr[5] = 32'h0000_000F; tbl_exp[5] = E_FENCE;
    tbl_instr[6] = 32'h0000_6003; tbl_exp[6] = E_ILL;     // load funct3=110
    tbl_instr[7] = 32'h0000_3023; tbl_exp[7] = E_ILL;     // store funct3=011
    tbl_instr[8] = 32'h0000_0067; tbl_exp[8] = E_JALR;

    // Reset state
    #12;
    check_eq("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    check_eq("rst_in_ready",  {63'd0, in_ready_o},  64'd1);
    check_eq("rst_ctrl",      {47'd0, out_ctrl_o},  64'd0);
    check_eq("rst_pc",        {32'd0, out_pc_o},    64'd0);
    step();
    rst_n = 1'b1;
    step();

    // addi x0: one-cycle latency into an empty queue
    push(32'h0000_0013, 32'h0000_0040);
    check_eq("addi_valid", {63'd0, out_valid_o}, 64'd1);
    check_eq("addi_ctrl",  {47'd0, out_ctrl_o},  {47'd0, E_OPIMM});
    check_eq("addi_instr", {32'd0, out_instr_o}, 64'h13);
    check_eq("addi_pc",    {32'd0, out_pc_o},    64'h40);
    check_eq("addi_ready", {63'd0, in_ready_o},  64'd1);
    pop();
    check_eq("addi_popped_valid", {63'd0, out_valid_o}, 64'd0);
    check_eq("addi_popped_instr", {32'd0, out_instr_o}, 64'd0);

    // Fill to full, third offer held, then drain in FIFO order
    in_valid_i = 1'b1;
    in_instr_i = 32'h0000_0033; in_pc_i = 32'h0000_0010;
    step();
    in_instr_i = 32'h0000_2003; in_pc_i = 32'h0000_0014;
    step();
    check_eq("full_ready",   {63'd0, in_ready_o}, 64'd0);
    check_eq("full_head_pc", {32'd0, out_pc_o},   64'h10);
    check_eq("full_head_op", {47'd0, out_ctrl_o}, {47'd0, E_OP});
    in_instr_i = 32'h0000_2023; in_pc_i = 32'h0000_0018;
    step();
    check_eq("held_ready",   {63'd0, in_ready_o}, 64'd0);
    check_eq("held_head_pc", {32'd0, out_pc_o},   64'h10);
    out_ready_i = 1'b1;
    step();
    check_eq("drain1_pc",    {32'd0, out_pc_o},   64'h14);
    check_eq("drain1_load",  {47'd0, out_ctrl_o}, {47'd0, E_LOAD});
    check_eq("drain1_ready", {63'd0, in_ready_o}, 64'd1);
    step();
    check_eq("drain2_pc",    {32'd0, out_pc_o},   64'h18);
    check_eq("drain2_store", {47'd0, out_ctrl_o}, {47'd0, E_STORE});
    in_valid_i = 1'b0;
    step();
    check_eq("drained_valid", {63'd0, out_valid_o}, 64'd0);
    out_ready_i = 1'b0;

    // JAL
    push(32'h0080_00EF, 32'h0000_0100);
    check_eq("jal_ctrl", {47'd0, out_ctrl_o}, {47'd0, E_JAL});
    check_eq("jal_pc",   {32'd0, out_pc_o},   64'h100);
    pop();

    // Unlisted opcode and JALR funct3=001 both enqueue as illegal
    push(32'h0000_307F, 32'h0000_0200);
    push(32'h0000_1067, 32'h0000_0204);
    check_eq("ill0_ctrl",  {47'd0, out_ctrl_o}, {47'd0, E_ILL});
    check_eq("ill0_pc",    {32'd0, out_pc_o},   64'h200);
    check_eq("ill_full",   {63'd0, in_ready_o}, 64'd0);
    pop();
    check_eq("ill1_ctrl",  {47'd0, out_ctrl_o}, {47'd0, E_ILL});
    check_eq("ill1_instr", {32'd0, out_instr_o}, 64'h1067);
    pop();

    // Remaining decode rows, one push/pop each
    for (int i = 0; i < 9; i++) begin
      push(tbl_instr[i], 32'h0000_1000 + 32'(i * 4));
      check_eq($sformatf("tbl%0d_valid", i), {63'd0, out_valid_o}, 64'd1);
      check_eq($sformatf("tbl%0d_ctrl", i),  {47'd0, out_ctrl_o},  {47'd0, tbl_exp[i]});
      pop();
    end

    // Flush of a full queue with a same-cycle offer
    push(32'h0000_0013, 32'h0000_0300);
    push(32'h0000_0013, 32'h0000_0304);
    check_eq("preflush_ready", {63'd0, in_ready_o}, 64'd0);
    flush_i    = 1'b1;
    in_valid_i = 1'b1;
    in_instr_i = 32'h0000_0033;
    in_pc_i    = 32'h0000_0308;
    step();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    check_eq("flush_valid", {63'd0, out_valid_o}, 64'd0);
    check_eq("flush_ready", {63'd0, in_ready_o},  64'd1);
    check_eq("flush_pc",    {32'd0, out_pc_o},    64'd0);
    step();
    check_eq("flush_dropped", {63'd0, out_valid_o}, 64'd0);
    push(32'h0000_00B7, 32'h0000_0310);
    check_eq("postflush_pc",   {32'd0, out_pc_o},   64'h310);
    check_eq("postflush_ctrl", {47'd0, out_ctrl_o}, {47'd0, E_LUI});
    pop();

    // Asynchronous reset with two entries queued
    push(32'h0000_0013, 32'h0000_0400);
    push(32'h0000_0013, 32'h0000_0404);
    check_eq("prerst_valid", {63'd0, out_valid_o}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", {63'd0, out_valid_o}, 64'd0);
    check_eq("midrst_ready", {63'd0, in_ready_o},  64'd1);
    check_eq("midrst_pc",    {32'd0, out_pc_o},    64'd0);
    check_eq("midrst_ctrl",  {47'd0, out_ctrl_o},  64'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
